// File: rtl/gate_tt_checker.sv
// gate_tt_checker: self-test reader for a 2-input logic gate.
// Walks the four input vectors 00, 01, 10, 11 onto the gate and holds each
// one for SETTLE+1 cycles. On the last cycle of each window it samples the
// gate output and compares it against TRUTH. A per-vector mismatch map and
// an error count build up during the run, and pass/fail is reported at the end.
module gate_tt_checker #(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_o,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    // The settle counter only has to reach SETTLE, but it must be at least one bit wide.
    localparam int CNT_W = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             mism;
    logic [3:0]       fail_next;
    logic [2:0]       err_next;

    // The vector index drives the gate directly. It stays at 3 after a run, so the drives hold 11.
    assign dut_a = idx[1];
    assign dut_b = idx[0];

    // Compare the current sample against the expected bit. Case inequality makes an X or Z output count as a failure.
    always_comb begin
        mism      = (dut_o !== TRUTH[idx]);
        fail_next = fail_vec | (4'(mism) << idx);
        err_next  = err_cnt + {2'b00, mism};
    end

    // Sequencer: this block accepts a start, times each settle window, records the samples and reports the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        idx      <= 2'd0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= 3'd0;
                        fail_vec <= 4'd0;
                    end
                end
                S_RUN: begin
                    if (cnt != SETTLE_C) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        // The final edge of this window records the sample and also moves on to the next vector.
                        fail_vec <= fail_next;
                        err_cnt  <= err_next;
                        if (idx == 2'd3) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == 4'd0);
                        end else begin
                            idx <= idx + 2'd1;
                            cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed testbench for gate_tt_checker. It checks a SETTLE=2 instance and a SETTLE=0 instance.
module tb_gate_tt_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 AND, 1 OR, 2 stuck-1, 3 stuck-0, 4 NAND.
    int   gmode  = 0;
    int   gmode0 = 0;

    function automatic logic gate_out(input int mode, input logic a, input logic b);
        case (mode)
            0:       return a & b;
            1:       return a | b;
            2:       return 1'b1;
            3:       return 1'b0;
            default: return ~(a & b);
        endcase
    endfunction

    logic       start, dut_o, dut_a, dut_b, busy, done, pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    logic       start_s0, dut_o_s0, dut_a_s0, dut_b_s0, busy_s0, done_s0, pass_s0;
    logic [2:0] err_cnt_s0;
    logic [3:0] fail_vec_s0;

    assign dut_o    = gate_out(gmode, dut_a, dut_b);
    assign dut_o_s0 = gate_out(gmode0, dut_a_s0, dut_b_s0);

    gate_tt_checker #(.TRUTH(4'b1000), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_o(dut_o),
        .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    gate_tt_checker #(.TRUTH(4'b1000), .SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start_s0), .dut_o(dut_o_s0),
        .dut_a(dut_a_s0), .dut_b(dut_b_s0), .busy(busy_s0), .done(done_s0),
        .pass(pass_s0), .err_cnt(err_cnt_s0), .fail_vec(fail_vec_s0)
    );

    int checks = 0;
    int errors = 0;

    // Raise start so that the next edge (E0) accepts it. Return 1 time unit after E0.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count the edges until done rises, up to a fixed limit. A value of -1 means done never rose.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if ({dut_a, dut_b, busy, done, pass} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {dut_a, dut_b, busy, done, pass}); end
        checks++; if ({err_cnt, fail_vec} !== 7'b0) begin errors++; $display("FAIL reset_results got %b want 0000000", {err_cnt, fail_vec}); end
        checks++; if ({dut_a_s0, dut_b_s0, busy_s0, done_s0, err_cnt_s0, fail_vec_s0} !== 11'b0) begin errors++; $display("FAIL reset_s0 got %b want 0", {dut_a_s0, dut_b_s0, busy_s0, done_s0, err_cnt_s0, fail_vec_s0}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_and_sequence();
        int ev;
        gmode = 0;
        pulse_start();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            ev = (k / 3 > 3) ? 3 : k / 3;
            checks++; if ({dut_a, dut_b} !== ev[1:0]) begin errors++; $display("FAIL and_drive k=%0d got %b want %b", k, {dut_a, dut_b}, ev[1:0]); end
            checks++; if (done !== 1'(k == 12)) begin errors++; $display("FAIL and_done k=%0d got %b want %b", k, done, 1'(k == 12)); end
            checks++; if (busy !== 1'(k != 12)) begin errors++; $display("FAIL and_busy k=%0d got %b want %b", k, busy, 1'(k != 12)); end
        end
        checks++; if ({pass, err_cnt, fail_vec} !== {1'b1, 3'd0, 4'b0000}) begin errors++; $display("FAIL and_result got pass=%b err=%0d fv=%b want pass=1 err=0 fv=0000", pass, err_cnt, fail_vec); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if ({dut_a, dut_b, done} !== 3'b111) begin errors++; $display("FAIL and_hold got %b want 111", {dut_a, dut_b, done}); end
    endtask

    task automatic test_or_gate();
        int lat;
        gmode = 1;
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        // The samples for vectors 0 and 1 have been taken by E0+6.
        checks++; if ({err_cnt, fail_vec} !== {3'd1, 4'b0010}) begin errors++; $display("FAIL or_partial got err=%0d fv=%b want err=1 fv=0010", err_cnt, fail_vec); end
        wait_done(lat);
        lat = lat + 6;
        checks++; if (lat !== 12) begin errors++; $display("FAIL or_latency got %0d want 12", lat); end
        checks++; if ({pass, err_cnt, fail_vec} !== {1'b0, 3'd2, 4'b0110}) begin errors++; $display("FAIL or_result got pass=%b err=%0d fv=%b want pass=0 err=2 fv=0110", pass, err_cnt, fail_vec); end
    endtask

    task automatic test_back_to_back();
        int lat;
        // The previous run (OR gate) has left the checker in DONE.
        pulse_start();
        checks++; if ({done, busy, err_cnt, fail_vec, dut_a, dut_b} !== {1'b0, 1'b1, 3'd0, 4'd0, 2'b00}) begin errors++; $display("FAIL b2b_restart got done=%b busy=%b err=%0d fv=%b ab=%b want 0 1 0 0000 00", done, busy, err_cnt, fail_vec, {dut_a, dut_b}); end
        wait_done(lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL b2b_latency got %0d want 12", lat); end
        checks++; if ({pass, err_cnt, fail_vec} !== {1'b0, 3'd2, 4'b0110}) begin errors++; $display("FAIL b2b_result got pass=%b err=%0d fv=%b want pass=0 err=2 fv=0110", pass, err_cnt, fail_vec); end
    endtask

    task automatic test_faulty_gates();
        int lat;
        int    modes [3] = '{2, 3, 4};
        logic [3:0] efv [3] = '{4'b0111, 4'b1000, 4'b1111};
        logic [2:0] eec [3] = '{3'd3, 3'd1, 3'd4};
        for (int m = 0; m < 3; m++) begin
            gmode = modes[m];
            pulse_start();
            wait_done(lat);
            checks++; if (lat !== 12) begin errors++; $display("FAIL fault_latency mode=%0d got %0d want 12", modes[m], lat); end
            checks++; if ({pass, err_cnt, fail_vec} !== {1'b0, eec[m], efv[m]}) begin errors++; $display("FAIL fault_result mode=%0d got pass=%b err=%0d fv=%b want pass=0 err=%0d fv=%b", modes[m], pass, err_cnt, fail_vec, eec[m], efv[m]); end
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        gmode = 2;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({dut_a, dut_b, busy, done, pass, err_cnt, fail_vec} !== 12'b0) begin errors++; $display("FAIL midrun_reset got ab=%b busy=%b done=%b pass=%b err=%0d fv=%b want all 0", {dut_a, dut_b}, busy, done, pass, err_cnt, fail_vec); end
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrun_idle got %b want 00", {busy, done}); end
        gmode = 0;
        pulse_start();
        wait_done(lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL midrun_rerun_latency got %0d want 12", lat); end
        checks++; if ({pass, err_cnt, fail_vec} !== {1'b1, 3'd0, 4'd0}) begin errors++; $display("FAIL midrun_rerun got pass=%b err=%0d fv=%b want 1 0 0000", pass, err_cnt, fail_vec); end
    endtask

    task automatic test_start_held();
        gmode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 11) begin
                checks++; if ({busy, done, dut_a, dut_b} !== 4'b1011) begin errors++; $display("FAIL held_k11 got %b want 1011", {busy, done, dut_a, dut_b}); end
            end
        end
        start = 1'b0;
        checks++; if ({busy, done, pass} !== 3'b011) begin errors++; $display("FAIL held_done got %b want 011", {busy, done, pass}); end
        @(posedge clk); #1;
    endtask

    task automatic test_settle0();
        int ev;
        gmode0 = 0;
        start_s0 = 1'b1;
        @(posedge clk); #1;
        start_s0 = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            ev = (k > 3) ? 3 : k;
            checks++; if ({dut_a_s0, dut_b_s0} !== ev[1:0]) begin errors++; $display("FAIL s0_drive k=%0d got %b want %b", k, {dut_a_s0, dut_b_s0}, ev[1:0]); end
            checks++; if (done_s0 !== 1'(k == 4)) begin errors++; $display("FAIL s0_done k=%0d got %b want %b", k, done_s0, 1'(k == 4)); end
        end
        checks++; if ({pass_s0, err_cnt_s0, fail_vec_s0} !== {1'b1, 3'd0, 4'd0}) begin errors++; $display("FAIL s0_result got pass=%b err=%0d fv=%b want 1 0 0000", pass_s0, err_cnt_s0, fail_vec_s0); end
        gmode0 = 2;
        start_s0 = 1'b1;
        @(posedge clk); #1;
        start_s0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({done_s0, pass_s0, err_cnt_s0, fail_vec_s0} !== {1'b1, 1'b0, 3'd3, 4'b0111}) begin errors++; $display("FAIL s0_stuck got done=%b pass=%b err=%0d fv=%b want 1 0 3 0111", done_s0, pass_s0, err_cnt_s0, fail_vec_s0); end
    endtask

    initial begin
        start    = 1'b0;
        start_s0 = 1'b0;
        test_reset();
        test_and_sequence();
        test_or_gate();
        test_back_to_back();
        test_faulty_gates();
        test_reset_midrun();
        test_start_held();
        test_settle0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Built-in self-test reader for a 2-input logic gate: drives all four input vectors onto the gate, samples the gate output after a settle window, and compares it against an expected truth table. It accumulates a per-vector mismatch map and an error count, then reports pass/fail. It is the checking end of the gate interface and replaces per-gate hand-written stimulus/monitor benches.

## Interface
- TRUTH, 4'b1000: expected output per vector; bit i is expected `o` for input index i = {a,b} (default is AND).
- SETTLE, 2: extra cycles each vector is held before sampling; legal range 0..15.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a test run; sampled on clk
- dut_o  input  1  output of gate under test
- dut_a  output  1  gate input a; equals idx[1]
- dut_b  output  1  gate input b; equals idx[0]
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next accepted start or reset
- pass  output  1  valid when done; 1 iff fail_vec == 0
- err_cnt  output  3  number of mismatching vectors, 0..4
- fail_vec  output  4  bit i set if vector i mismatched

## Operation
- One clock (clk). Reset is synchronous and active-high (rst).
- States: IDLE, RUN, DONE.
- Internal: idx[1:0] (vector index), cnt (settle counter, width clog2(SETTLE+1), minimum 1 bit).
- IDLE/DONE with start=1: enter RUN, idx=0, cnt=0, fail_vec=0, err_cnt=0, done=0, pass=0, busy=1.
- RUN, each edge:
  - If cnt != SETTLE: cnt++.
  - If cnt == SETTLE: sample dut_o. On mismatch with TRUTH[idx] (case inequality, so X/Z counts as mismatch), set fail_vec[idx] and increment err_cnt.
  - Then, if idx == 3: go to DONE. Otherwise idx++ and cnt=0.
- On DONE entry: busy=0, done=1, pass=(final fail_vec == 0). Final fail_vec and err_cnt include the last sample taken on that same edge.
- Vector order is 00, 01, 10, 11 (dut_a, dut_b). Drives change only on clk edges.
- start while in RUN is ignored and does not affect timing.
- After DONE, drives hold 11 until the next start.
- Reset, including mid-run: state=IDLE, idx=0, cnt=0, all outputs 0 (dut_a, dut_b, busy, done, pass, err_cnt, fail_vec). Partial results are discarded.

## Timing
- Start accepted at edge E0. Vector i is driven from E0 + i*(SETTLE+1) and held SETTLE+1 cycles.
- Vector i is sampled at edge E0 + (i+1)*(SETTLE+1), i.e. the edge ending its window. That edge also drives the next vector.
- done rises at E0 + 4*(SETTLE+1): 12 cycles for SETTLE=2, 4 cycles for SETTLE=0.
- fail_vec and err_cnt update at sample edges and are monotonic within a run.
- Back-to-back runs: start in DONE is accepted at that edge. done falls on the same edge busy rises.
- DUT combinational delay must be less than one cycle when SETTLE=0.

## Test plan
- AND gate DUT, defaults: start pulse at E0 -> dut_a/dut_b step 00, 01, 10, 11, each held 3 cycles. done=1 at E0+12, pass=1, err_cnt=0, fail_vec=0000.
- OR gate DUT, TRUTH=4'b1000 -> fail_vec=0110, err_cnt=2, pass=0 at E0+12.
- dut_o stuck at 1 -> fail_vec=0111, err_cnt=3, pass=0. dut_o undriven (X) -> fail_vec=1111, err_cnt=4.
- Reset at E0+5 -> next cycle all outputs 0 and state IDLE. New start at E5' with AND DUT -> done at E5'+12, pass=1.
- start held high for all of RUN -> single run, done still at E0+12. start in DONE -> done cleared and busy=1 next edge, second run completes with identical results.
- SETTLE=0 instance, AND DUT -> each vector held 1 cycle, done at E0+4, pass=1.
